// File: rtl/lane_grid_drawer.sv
// rtl/lane_grid_drawer.sv - 8x4 falling-note grid: shifts one row per beat and redraws it as 8x8 pixel cells.
module lane_grid_drawer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int X0          = 64,
    parameter int Y0          = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       shiftSong,
    input  logic       beatIncremented,
    input  logic [3:0] noteRow,
    output logic       readyForSong,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [3:0] noteNow,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAW,
        S_WAITBEAT,
        S_READY
    } state_t;

    localparam logic [23:0] TIMER_MAX = 24'(BEAT_CYCLES - 1);

    state_t           r_state;
    logic [7:0][3:0]  r_grid;
    logic [3:0]       r_note;
    logic [23:0]      r_timer;
    logic [11:0]      r_pix;

    logic [7:0][3:0]  w_shifted;
    logic [7:0][3:0]  w_src;
    logic             w_cell;
    logic [7:0]       w_x;
    logic [6:0]       w_y;
    logic [2:0]       w_colour;

    // Pixel index bits: [10:8]=row, [7:6]=lane, [5:3]=py, [2:0]=px.
    // The SHIFT cycle emits pixel 0, so it must read the grid as it will be after the shift.
    assign w_shifted = {r_grid[6:0], r_note};
    assign w_src     = (r_state == S_SHIFT) ? w_shifted : r_grid;
    assign w_cell    = w_src[r_pix[10:8]][r_pix[7:6]];
    assign w_x       = 8'(X0) + {3'b000, r_pix[7:6], r_pix[2:0]};
    assign w_y       = 7'(Y0) + {1'b0, r_pix[10:8], r_pix[5:3]};

    always_comb begin
        w_colour = 3'b000;
        if (w_cell) begin
            case (r_pix[7:6])
                2'd0:    w_colour = 3'b100;
                2'd1:    w_colour = 3'b010;
                2'd2:    w_colour = 3'b001;
                default: w_colour = 3'b110;
            endcase
        end
    end

    assign noteNow = r_grid[7];
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grid       <= '0;
            r_note       <= '0;
            r_timer      <= '0;
            r_pix        <= '0;
            x            <= '0;
            y            <= '0;
            colour       <= '0;
            plot         <= 1'b0;
            readyForSong <= 1'b0;
        end else begin
            plot         <= 1'b0;
            readyForSong <= 1'b0;
            if (r_timer != TIMER_MAX)
                r_timer <= r_timer + 24'd1;

            case (r_state)
                S_IDLE: begin
                    if (shiftSong) begin
                        r_grid <= '0;
                    end else if (beatIncremented) begin
                        r_note  <= noteRow;
                        r_timer <= '0;
                        r_pix   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_grid  <= w_shifted;
                    x       <= w_x;
                    y       <= w_y;
                    colour  <= w_colour;
                    plot    <= 1'b1;
                    r_pix   <= 12'd1;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    if (r_pix[11]) begin
                        r_state <= S_WAITBEAT;
                    end else begin
                        x      <= w_x;
                        y      <= w_y;
                        colour <= w_colour;
                        plot   <= 1'b1;
                        r_pix  <= r_pix + 12'd1;
                    end
                end
                S_WAITBEAT: begin
                    if (r_timer == TIMER_MAX) begin
                        readyForSong <= 1'b1;
                        r_state      <= S_READY;
                    end
                end
                S_READY: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lane_grid_drawer.sv
// tb/tb_lane_grid_drawer.sv - randomized bench with a timeline model of the grid drawer.
module tb_lane_grid_drawer;

    localparam int BC       = 3000;
    localparam int BC_SHORT = 100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       shiftSong = 1'b0;
    logic       beatIncremented = 1'b0;
    logic [3:0] noteRow = 4'd0;
    logic       readyForSong, plot, busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic [3:0] noteNow;

    logic       beat_s = 1'b0;
    logic [3:0] note_s = 4'd0;
    logic       ready_s, plot_s, busy_s;
    logic [7:0] x_s;
    logic [6:0] y_s;
    logic [2:0] colour_s;
    logic [3:0] noteNow_s;

    lane_grid_drawer #(.BEAT_CYCLES(BC), .X0(64), .Y0(8)) u_dut (
        .clock(clock), .reset(reset), .shiftSong(shiftSong),
        .beatIncremented(beatIncremented), .noteRow(noteRow),
        .readyForSong(readyForSong), .x(x), .y(y), .colour(colour),
        .plot(plot), .noteNow(noteNow), .busy(busy)
    );

    lane_grid_drawer #(.BEAT_CYCLES(BC_SHORT), .X0(64), .Y0(8)) u_dut_short (
        .clock(clock), .reset(reset), .shiftSong(1'b0),
        .beatIncremented(beat_s), .noteRow(note_s),
        .readyForSong(ready_s), .x(x_s), .y(y_s), .colour(colour_s),
        .plot(plot_s), .noteNow(noteNow_s), .busy(busy_s)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Inputs as seen by the most recent rising edge.
    int         cyc = 0;
    logic       s_reset, s_shift, s_beat;
    logic [3:0] s_note;
    always @(posedge clock) begin
        cyc++;
        s_reset = reset;
        s_shift = shiftSong;
        s_beat  = beatIncremented;
        s_note  = noteRow;
    end

    // Timeline model: a beat accepted at edge a shows pixel k at a+1+k and
    // the ready pulse at a+max(BC,2050); the block is busy from a through ready.
    logic [3:0] mgrid [8];
    logic [2:0] lane_col [4] = '{3'b100, 3'b010, 3'b001, 3'b110};
    logic       m_active = 1'b0, m_rst = 1'b0, m_started = 1'b0;
    int         m_acc = 0, m_ready = 0;
    logic [3:0] m_note = 4'd0;

    // Frame statistics gathered from the DUT for literal checks.
    int st_plots, st_nz, st_nz_bad, st_ready, st_lat, st_rise;
    int st_fx, st_fy, st_lx, st_ly;
    logic prev_busy = 1'b0;

    task automatic clear_stats();
        st_plots = 0; st_nz = 0; st_nz_bad = 0; st_ready = 0; st_lat = -1;
        st_fx = -1; st_fy = -1; st_lx = -1; st_ly = -1;
    endtask

    always @(negedge clock) begin
        logic       idle_before, e_plot, e_ready, e_busy;
        logic [7:0] e_x;
        logic [6:0] e_y;
        logic [2:0] e_col;
        int         k, r, l;
        if (s_reset) begin
            m_active  = 1'b0;
            m_rst     = 1'b1;
            m_started = 1'b1;
            for (int i = 0; i < 8; i++) mgrid[i] = 4'd0;
        end else begin
            m_rst = 1'b0;
            idle_before = !m_active || (cyc >= m_ready + 2);
            if (idle_before) begin
                if (s_shift) begin
                    for (int i = 0; i < 8; i++) mgrid[i] = 4'd0;
                end else if (s_beat) begin
                    m_active = 1'b1;
                    m_acc    = cyc;
                    m_ready  = cyc + ((BC > 2050) ? BC : 2050);
                    m_note   = s_note;
                end
            end
            if (m_active && cyc == m_acc + 1) begin
                for (int i = 7; i > 0; i--) mgrid[i] = mgrid[i-1];
                mgrid[0] = m_note;
            end
        end

        e_plot  = m_active && (cyc >= m_acc + 1) && (cyc <= m_acc + 2048);
        e_ready = m_active && (cyc == m_ready);
        e_busy  = m_active && (cyc >= m_acc) && (cyc <= m_ready);
        e_x = 8'd0; e_y = 7'd0; e_col = 3'd0;
        if (e_plot) begin
            k = cyc - m_acc - 1;
            r = k / 256;
            l = (k / 64) % 4;
            e_x   = 8'(64 + 8 * l + (k % 8));
            e_y   = 7'(8 + 8 * r + ((k / 8) % 8));
            e_col = mgrid[r][l] ? lane_col[l] : 3'b000;
        end

        if (m_started) begin
            n_cmp++;
            if (e_plot || m_rst) begin
                if ({plot, readyForSong, busy, noteNow, x, y, colour} !==
                    {e_plot, e_ready, e_busy, mgrid[7], e_x, e_y, e_col}) begin
                    n_fail++;
                    $display("FAIL cycle_check cyc=%0d got plot=%b rdy=%b busy=%b note=%b x=%0d y=%0d col=%b want plot=%b rdy=%b busy=%b note=%b x=%0d y=%0d col=%b",
                             cyc, plot, readyForSong, busy, noteNow, x, y, colour,
                             e_plot, e_ready, e_busy, mgrid[7], e_x, e_y, e_col);
                end
            end else if ({plot, readyForSong, busy, noteNow} !== {e_plot, e_ready, e_busy, mgrid[7]}) begin
                n_fail++;
                $display("FAIL cycle_check cyc=%0d got plot=%b rdy=%b busy=%b note=%b want plot=%b rdy=%b busy=%b note=%b",
                         cyc, plot, readyForSong, busy, noteNow, e_plot, e_ready, e_busy, mgrid[7]);
            end
        end

        if (busy && !prev_busy) st_rise = cyc;
        prev_busy = busy;
        if (plot === 1'b1) begin
            if (st_plots == 0) begin st_fx = x; st_fy = y; end
            st_lx = x; st_ly = y;
            st_plots++;
            if (colour != 3'b000) begin
                st_nz++;
                if (x < 64 || x > 71 || y < 8 || y > 15 || colour != 3'b100) st_nz_bad++;
            end
        end
        if (readyForSong === 1'b1) begin
            st_ready++;
            st_lat = cyc - st_rise;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic beat(input logic [3:0] n);
        beatIncremented = 1'b1;
        noteRow = n;
        step();
        beatIncremented = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 4000) begin
            step();
            t++;
        end
        if (t >= 4000) chk("wait_idle_timeout", t, 0);
        step();
    endtask

    task automatic wait_plots(input int n);
        int t;
        t = 0;
        while (st_plots < n && t < 4000) begin
            step();
            t++;
        end
        if (t >= 4000) chk("wait_plots_timeout", st_plots, n);
    endtask

    initial begin
        int t, last_p, rdy_at, np, rc;
        clear_stats();
        st_rise = 0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_plot", plot, 0);
        chk("reset_note", noteNow, 0);

        // Single frame with lane 0 set in the top row.
        clear_stats();
        beat(4'b0001);
        wait_idle();
        chk("f1_plots", st_plots, 2048);
        chk("f1_first_x", st_fx, 64);
        chk("f1_first_y", st_fy, 8);
        chk("f1_last_x", st_lx, 95);
        chk("f1_last_y", st_ly, 71);
        chk("f1_nonzero", st_nz, 64);
        chk("f1_nonzero_bad", st_nz_bad, 0);
        chk("f1_ready_cnt", st_ready, 1);
        chk("f1_ready_lat", st_lat, 3000);

        // Random frames with random ignored pulses while busy and random clears while idle.
        for (int f = 0; f < 3; f++) begin
            if ($urandom_range(0, 2) == 0) begin
                shiftSong = 1'b1;
                step();
                shiftSong = 1'b0;
            end
            beat(4'($urandom_range(0, 15)));
            t = 0;
            while (busy === 1'b1 && t < 4000) begin
                beatIncremented = ($urandom_range(0, 15) == 0);
                shiftSong       = ($urandom_range(0, 15) == 0);
                noteRow         = 4'($urandom_range(0, 15));
                step();
                t++;
            end
            beatIncremented = 1'b0;
            shiftSong = 1'b0;
            step();
        end
        wait_idle();

        // Eight beats of lane 3 then one empty beat.
        for (int b = 0; b < 9; b++) begin
            beat((b < 8) ? 4'b1000 : 4'b0000);
            wait_idle();
            if (b >= 7) chk("hit_line_lane3", noteNow, 4'b1000);
        end

        // Clear and beat together in IDLE: clear wins, nothing drawn.
        clear_stats();
        shiftSong = 1'b1;
        beatIncremented = 1'b1;
        noteRow = 4'b1111;
        step();
        shiftSong = 1'b0;
        beatIncremented = 1'b0;
        repeat (4) step();
        chk("clr_note", noteNow, 0);
        chk("clr_busy", busy, 0);
        chk("clr_plots", st_plots, 0);
        beat(4'b0000);
        wait_idle();
        chk("black_plots", st_plots, 2048);
        chk("black_nonzero", st_nz, 0);

        // Beat pulses during DRAW and WAITBEAT are ignored.
        clear_stats();
        beat(4'($urandom_range(0, 15)));
        wait_plots(100);
        beat(4'b1111);
        wait_plots(2048);
        repeat (20) step();
        beat(4'b1111);
        wait_idle();
        repeat (10) step();
        chk("ign_plots", st_plots, 2048);
        chk("ign_ready", st_ready, 1);

        // Reset in the middle of a frame.
        clear_stats();
        beat(4'b0110);
        wait_plots(500);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_plot", plot, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_note", noteNow, 0);
        repeat (5) step();
        chk("rst_mid_ready", st_ready, 0);
        clear_stats();
        beat(4'b0010);
        wait_idle();
        chk("after_rst_first_x", st_fx, 64);
        chk("after_rst_first_y", st_fy, 8);
        chk("after_rst_ready", st_ready, 1);

        // Short beat period: ready two cycles after the last pixel.
        beat_s = 1'b1;
        note_s = 4'b0100;
        step();
        beat_s = 1'b0;
        last_p = -1; rdy_at = -1; np = 0; rc = 0;
        for (int i = 1; i < 2200; i++) begin
            if (plot_s === 1'b1) begin
                if (np == 0) begin
                    chk("short_first_x", x_s, 64);
                    chk("short_first_y", y_s, 8);
                    chk("short_first_col", colour_s, 0);
                end
                np++;
                last_p = i;
            end
            if (ready_s === 1'b1) begin rc++; rdy_at = i; end
            step();
        end
        chk("short_plots", np, 2048);
        chk("short_ready_cnt", rc, 1);
        chk("short_ready_gap", rdy_at - last_p, 2);
        chk("short_busy_end", busy_s, 0);
        chk("short_note", noteNow_s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
